// File: rtl/seven_segment_monitor.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_monitor
// Description : Debounces a 7-segment pattern, decodes the digit and flags
//               out-of-sequence digits and illegal patterns. The error counter
//               is built only when SEVEN_SEGMENT_MONITOR_ERRCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_monitor #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segments,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       update,
    output logic       seq_error,
    output logic       bad_pattern,
    output logic [7:0] err_count
);

    localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] seg_q;
    logic [6:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       update_q, update_d;
    logic       seq_err_q, seq_err_d;
    logic       bad_q, bad_d;

    logic       accept;
    logic       dec_valid;
    logic       dec_blank;
    logic [3:0] dec_digit;
    logic [3:0] next_digit;

    always_comb begin
        if (segments != seg_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q != STABLE_C) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Accept on the edge where the stable run completes; the accepted pattern
    // is remembered so a re-stabilised identical pattern stays silent.
    assign accept = (cnt_d == STABLE_C) && (seg_q != last_q);

    always_comb begin
        dec_valid = 1'b1;
        dec_blank = 1'b0;
        dec_digit = 4'd0;
        case (seg_q)
            7'h3F: dec_digit = 4'd0;
            7'h06: dec_digit = 4'd1;
            7'h5B: dec_digit = 4'd2;
            7'h4F: dec_digit = 4'd3;
            7'h66: dec_digit = 4'd4;
            7'h6D: dec_digit = 4'd5;
            7'h7D: dec_digit = 4'd6;
            7'h07: dec_digit = 4'd7;
            7'h7F: dec_digit = 4'd8;
            7'h6F: dec_digit = 4'd9;
            7'h00: begin
                dec_valid = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
    end

    assign next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        digit_d   = digit_q;
        valid_d   = valid_q;
        update_d  = 1'b0;
        seq_err_d = 1'b0;
        bad_d     = 1'b0;
        if (accept) begin
            last_d   = seg_q;
            update_d = 1'b1;
            if (dec_valid) begin
                digit_d   = dec_digit;
                valid_d   = 1'b1;
                state_d   = LOCKED;
                seq_err_d = (state_q == LOCKED) && (dec_digit != next_digit);
            end else begin
                valid_d = 1'b0;
                bad_d   = ~dec_blank;
                state_d = UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= UNLOCKED;
            seg_q     <= 7'h00;
            last_q    <= 7'h00;
            cnt_q     <= 4'd0;
            digit_q   <= 4'd0;
            valid_q   <= 1'b0;
            update_q  <= 1'b0;
            seq_err_q <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_q     <= segments;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            update_q  <= update_d;
            seq_err_q <= seq_err_d;
            bad_q     <= bad_d;
        end
    end

`ifdef SEVEN_SEGMENT_MONITOR_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'h00;
        end else if ((seq_err_d | bad_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign seq_error   = seq_err_q;
    assign bad_pattern = bad_q;

endmodule
`default_nettype wire
